// File: rtl/alu_seq.sv
// Handshaked ALU: logic/arith ops finish on the accept edge, shifts take k edges, MUL takes WIDTH edges.
// Latency: 1 cycle (single), k+1 (shift by k>0), WIDTH+1 (MUL) from accept to out_valid_o.
// Backpressure: result and flags held in DONE until out_ready_i; no new request accepted meanwhile.
module alu_seq #(
   parameter int WIDTH  = 8,
   parameter bit MUL_EN = 1'b1
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             flush_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [3:0]       opcode_i,
   input  logic [WIDTH-1:0] rs_i,
   input  logic [WIDTH-1:0] rt_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] alu_result_o,
   output logic             set_o,
   output logic             zero_o,
   output logic             carry_o,
   output logic             ovf_o,
   output logic             err_o
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   typedef struct packed {
      logic set;
      logic zero;
      logic carry;
      logic ovf;
      logic err;
   } flags_t;

   state_t           state_q, state_d;
   logic             is_mul_q, shl_q;
   logic [WIDTH-1:0] opa_q, opb_q, acc_q, res_q;
   logic [CW-1:0]    cnt_q;
   flags_t           flg_q;

   logic [WIDTH:0]   sum, diff;
   logic [WIDTH-1:0] sc_res, neg_rs, shf, mac, step_res;
   logic [CW-1:0]    k_sat;
   logic             multi, slt, last;
   flags_t           sc_flg, step_flg;

   // Single-cycle results, evaluated on the request operands at accept time.
   always_comb begin
      sc_res = '0;
      sc_flg = '0;
      multi  = 1'b0;
      sum    = {1'b0, rs_i} + {1'b0, rt_i};
      diff   = {1'b0, rs_i} - {1'b0, rt_i};
      neg_rs = '0 - rs_i;
      slt    = $signed(rs_i) < $signed(rt_i);
      k_sat  = (rt_i >= WIDTH'(WIDTH)) ? CW'(WIDTH) : rt_i[CW-1:0];
      case (opcode_i)
         4'd0: sc_res = rs_i & rt_i;
         4'd1: begin
            sc_res       = sum[WIDTH-1:0];
            sc_flg.carry = sum[WIDTH];
            sc_flg.ovf   = (rs_i[WIDTH-1] == rt_i[WIDTH-1]) && (sum[WIDTH-1] != rs_i[WIDTH-1]);
         end
         4'd2, 4'd3: begin
            if (k_sat == '0) sc_res = rs_i;
            else             multi  = 1'b1;
         end
         4'd4: begin
            sc_res       = diff[WIDTH-1:0];
            sc_flg.carry = ~diff[WIDTH];
            sc_flg.ovf   = (rs_i[WIDTH-1] != rt_i[WIDTH-1]) && (diff[WIDTH-1] != rs_i[WIDTH-1]);
         end
         4'd5: begin
            sc_flg.set = slt;
            sc_res     = {{(WIDTH-1){1'b0}}, slt};
         end
         4'd6: begin
            sc_res     = rs_i[WIDTH-1] ? neg_rs : rs_i;
            sc_flg.ovf = (rs_i == {1'b1, {(WIDTH-1){1'b0}}});
         end
         4'd7: sc_res = {{(WIDTH-1){1'b0}}, (rs_i == rt_i)};
         4'd8: begin
            if (MUL_EN) multi      = 1'b1;
            else        sc_flg.err = 1'b1;
         end
         4'd9:  sc_res = rs_i | rt_i;
         4'd10: sc_res = rs_i ^ rt_i;
         default: sc_flg.err = 1'b1;
      endcase
      sc_flg.zero = (sc_res == '0);
   end

   // One iterative step: shift the working operand, or shift-add for MUL.
   always_comb begin
      shf           = shl_q ? (opa_q << 1) : (opa_q >> 1);
      mac           = acc_q + (opb_q[0] ? opa_q : '0);
      step_res      = is_mul_q ? mac : shf;
      last          = (cnt_q == CW'(1));
      step_flg      = '0;
      step_flg.zero = (step_res == '0);
   end

   always_comb begin
      state_d     = state_q;
      in_ready_o  = (state_q == IDLE) && rst_n_i;
      out_valid_o = (state_q == DONE);
      case (state_q)
         IDLE:    if (in_valid_i) state_d = multi ? BUSY : DONE;
         BUSY:    if (last)       state_d = DONE;
         DONE:    if (out_ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (flush_i) state_d = IDLE;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         is_mul_q <= 1'b0;
         shl_q    <= 1'b0;
         opa_q    <= '0;
         opb_q    <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         res_q    <= '0;
         flg_q    <= '0;
      end else if (flush_i) begin
         acc_q <= '0;
         cnt_q <= '0;
         res_q <= '0;
         flg_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid_i && multi) begin
                  is_mul_q <= (opcode_i == 4'd8);
                  shl_q    <= (opcode_i != 4'd3);
                  opa_q    <= rs_i;
                  opb_q    <= rt_i;
                  acc_q    <= '0;
                  cnt_q    <= (opcode_i == 4'd8) ? CW'(WIDTH) : k_sat;
               end else if (in_valid_i) begin
                  res_q <= sc_res;
                  flg_q <= sc_flg;
               end
            end
            BUSY: begin
               acc_q <= mac;
               opa_q <= shf;
               opb_q <= opb_q >> 1;
               cnt_q <= cnt_q - CW'(1);
               if (last) begin
                  res_q <= step_res;
                  flg_q <= step_flg;
               end
            end
            default: ;
         endcase
      end
   end

   assign alu_result_o = res_q;
   assign set_o        = flg_q.set;
   assign zero_o       = flg_q.zero;
   assign carry_o      = flg_q.carry;
   assign ovf_o        = flg_q.ovf;
   assign err_o        = flg_q.err;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (WIDTH=8): directed vector table, handshake/reset/flush sequences, random ops vs model.
module tb_alu_seq;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         flush = 1'b0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic [3:0]   opcode = '0;
   logic [W-1:0] rs = '0, rt = '0;

   logic         in_ready, out_valid, set_f, zero_f, carry_f, ovf_f, err_f;
   logic [W-1:0] result;
   logic         nm_in_ready, nm_out_valid, nm_set, nm_zero, nm_carry, nm_ovf, nm_err;
   logic [W-1:0] nm_result;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   alu_seq #(.WIDTH(W), .MUL_EN(1'b1)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .in_valid_i(in_valid),
      .in_ready_o(in_ready), .opcode_i(opcode), .rs_i(rs), .rt_i(rt),
      .out_valid_o(out_valid), .out_ready_i(out_ready), .alu_result_o(result),
      .set_o(set_f), .zero_o(zero_f), .carry_o(carry_f), .ovf_o(ovf_f), .err_o(err_f)
   );

   alu_seq #(.WIDTH(W), .MUL_EN(1'b0)) dut_nm (
      .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .in_valid_i(in_valid),
      .in_ready_o(nm_in_ready), .opcode_i(opcode), .rs_i(rs), .rt_i(rt),
      .out_valid_o(nm_out_valid), .out_ready_i(out_ready), .alu_result_o(nm_result),
      .set_o(nm_set), .zero_o(nm_zero), .carry_o(nm_carry), .ovf_o(nm_ovf), .err_o(nm_err)
   );

   typedef struct {
      int res, set, zero, carry, ovf, err, lat;
   } exp_t;

   typedef struct {
      int   op, a, b;
      exp_t e;
   } vec_t;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
      end
   endtask

   // Reference model: plain integer arithmetic on the opcode definitions.
   function automatic exp_t model(input int op, input int a, input int b);
      exp_t e;
      int   sa, sb, r, k;
      e  = '{default: 0};
      sa = (a > 127) ? a - 256 : a;
      sb = (b > 127) ? b - 256 : b;
      k  = (b > W) ? W : b;
      r  = 0;
      case (op)
         0: r = a & b;
         1: begin r = a + b; e.carry = int'(r > 255); e.ovf = int'((sa + sb > 127) || (sa + sb < -128)); end
         2: begin r = a << k; e.lat = k; end
         3: begin r = a >> k; e.lat = k; end
         4: begin r = a - b; e.carry = int'(a >= b); e.ovf = int'((sa - sb > 127) || (sa - sb < -128)); end
         5: begin e.set = int'(sa < sb); r = e.set; end
         6: begin r = (sa < 0) ? -sa : sa; e.ovf = int'(sa == -128); end
         7: r = int'(a == b);
         8: begin r = a * b; e.lat = W; end
         9: r = a | b;
         10: r = a ^ b;
         default: begin r = 0; e.err = 1; end
      endcase
      e.res  = r & 255;
      e.zero = int'(e.res == 0);
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one op, measure edges from accept to out_valid, check, optionally stall, then consume.
   task automatic run_op(input string tag, input int op, input int a, input int b, input exp_t e, input int hold);
      int n;
      int held;
      n = 0;
      while (!in_ready && n < 50) begin tick(); n++; end
      chk({tag, ".in_ready"}, int'(in_ready), 1);
      in_valid = 1'b1; opcode = 4'(op); rs = W'(a); rt = W'(b);
      tick();
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 40) begin tick(); n++; end
      chk({tag, ".latency"}, n, e.lat);
      chk({tag, ".res"}, int'(result), e.res);
      chk({tag, ".set"}, int'(set_f), e.set);
      chk({tag, ".zero"}, int'(zero_f), e.zero);
      chk({tag, ".carry"}, int'(carry_f), e.carry);
      chk({tag, ".ovf"}, int'(ovf_f), e.ovf);
      chk({tag, ".err"}, int'(err_f), e.err);
      held = int'(result);
      for (int i = 0; i < hold; i++) begin
         tick();
         chk({tag, ".hold_res"}, int'(result), held);
         chk({tag, ".hold_valid"}, int'(out_valid), 1);
         chk({tag, ".hold_in_ready"}, int'(in_ready), 0);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({tag, ".consumed_valid"}, int'(out_valid), 0);
      chk({tag, ".ready_after"}, int'(in_ready), 1);
   endtask

   task automatic watch_no_valid(input string tag, input int cycles);
      int seen;
      seen = 0;
      for (int i = 0; i < cycles; i++) begin
         tick();
         if (out_valid) seen = 1;
      end
      chk(tag, seen, 0);
   endtask

   vec_t vecs[$];

   function automatic vec_t mk(input int op, input int a, input int b, input int res, input int set,
                               input int zero, input int carry, input int ovf, input int err, input int lat);
      vec_t v;
      v.op = op; v.a = a; v.b = b;
      v.e = '{res: res, set: set, zero: zero, carry: carry, ovf: ovf, err: err, lat: lat};
      return v;
   endfunction

   initial begin
      exp_t e;
      int   op, a, b;

      //          op  a     b     res   set z  c  o  err lat
      vecs.push_back(mk(1,  'h7F, 'h01, 'h80, 0, 0, 0, 1, 0, 0));
      vecs.push_back(mk(4,  'h05, 'h07, 'hFE, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1,  'hFF, 'h01, 'h00, 0, 1, 1, 0, 0, 0));
      vecs.push_back(mk(4,  'h80, 'h01, 'h7F, 0, 0, 1, 1, 0, 0));
      vecs.push_back(mk(2,  'h81, 3,    'h08, 0, 0, 0, 0, 0, 3));
      vecs.push_back(mk(3,  'h80, 0,    'h80, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(3,  'h80, 7,    'h01, 0, 0, 0, 0, 0, 7));
      vecs.push_back(mk(2,  'hFF, 200,  'h00, 0, 1, 0, 0, 0, 8));
      vecs.push_back(mk(8,  13,   11,   'h8F, 0, 0, 0, 0, 0, 8));
      vecs.push_back(mk(5,  'hFE, 'h01, 'h01, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk(6,  'h80, 0,    'h80, 0, 0, 0, 1, 0, 0));
      vecs.push_back(mk(6,  'hF6, 0,    'h0A, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(13, 'h12, 'h34, 'h00, 0, 1, 0, 0, 1, 0));
      vecs.push_back(mk(0,  'hF0, 'h3C, 'h30, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(9,  'hF0, 'h3C, 'hFC, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(10, 'hF0, 'h3C, 'hCC, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(7,  'h5A, 'h5A, 'h01, 0, 0, 0, 0, 0, 0));

      // Reset state
      tick(); tick();
      chk("rst.in_ready", int'(in_ready), 0);
      chk("rst.out_valid", int'(out_valid), 0);
      chk("rst.result", int'(result), 0);
      chk("rst.flags", int'({set_f, zero_f, carry_f, ovf_f, err_f}), 0);
      @(negedge clk); rst_n = 1'b1;
      tick();
      chk("rst.in_ready_after", int'(in_ready), 1);

      foreach (vecs[i]) run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].e, 0);

      // Reset in the 3rd BUSY cycle of MUL 15*17
      in_valid = 1'b1; opcode = 4'd8; rs = 8'd15; rt = 8'd17;
      tick();
      in_valid = 1'b0;
      tick(); tick();
      rst_n = 1'b0;
      #1;
      chk("rstmul.out_valid", int'(out_valid), 0);
      chk("rstmul.result", int'(result), 0);
      chk("rstmul.flags", int'({set_f, zero_f, carry_f, ovf_f, err_f}), 0);
      chk("rstmul.in_ready", int'(in_ready), 0);
      @(negedge clk); rst_n = 1'b1;
      tick();
      chk("rstmul.in_ready_after", int'(in_ready), 1);
      watch_no_valid("rstmul.no_stale", 12);

      // Backpressure on MUL, then immediate next request
      run_op("bp_mul", 8, 13, 11, model(8, 13, 11), 5);
      run_op("bp_next", 1, 2, 3, model(1, 2, 3), 0);

      // Flush while SLL-by-5 is busy
      in_valid = 1'b1; opcode = 4'd2; rs = 8'h01; rt = 8'd5;
      tick();
      in_valid = 1'b0;
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flbusy.out_valid", int'(out_valid), 0);
      chk("flbusy.in_ready", int'(in_ready), 1);
      watch_no_valid("flbusy.no_valid", 8);

      // Flush in DONE wins over out_ready
      in_valid = 1'b1; opcode = 4'd1; rs = 8'd3; rt = 8'd4;
      tick();
      in_valid = 1'b0;
      chk("fldone.valid_before", int'(out_valid), 1);
      flush = 1'b1; out_ready = 1'b1;
      tick();
      flush = 1'b0; out_ready = 1'b0;
      chk("fldone.out_valid", int'(out_valid), 0);
      chk("fldone.in_ready", int'(in_ready), 1);
      watch_no_valid("fldone.no_valid", 4);

      // Request on a flush edge is not accepted
      in_valid = 1'b1; opcode = 4'd1; rs = 8'd9; rt = 8'd9; flush = 1'b1;
      tick();
      in_valid = 1'b0; flush = 1'b0;
      chk("flreq.in_ready", int'(in_ready), 1);
      chk("flreq.out_valid", int'(out_valid), 0);
      watch_no_valid("flreq.no_valid", 4);

      // MUL_EN=0 instance: opcode 8 is illegal and single-cycle
      flush = 1'b1;
      tick();
      flush = 1'b0;
      in_valid = 1'b1; opcode = 4'd8; rs = 8'd3; rt = 8'd5;
      tick();
      in_valid = 1'b0;
      chk("nomul.out_valid", int'(nm_out_valid), 1);
      chk("nomul.err", int'(nm_err), 1);
      chk("nomul.result", int'(nm_result), 0);
      chk("nomul.zero", int'(nm_zero), 1);
      flush = 1'b1;
      tick();
      flush = 1'b0;

      // Random ops against the model
      for (int i = 0; i < 150; i++) begin
         op = int'($urandom_range(0, 15));
         a  = int'($urandom_range(0, 255));
         b  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 9));
         e  = model(op, a, b);
         run_op($sformatf("rnd%0d_op%0d", i, op), op, a, b, e, int'($urandom_range(0, 2)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
